// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared constants and types for the BCD 7-segment scanner
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index of the digit currently being lit (0 = units)
  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD code to active-low 7-segment pattern
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Map each BCD code to its pattern; codes 10..15 are not BCD and show a dash
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// rtl/bcd_7seg_scan.sv - 4-digit multiplexed common-anode display driver; optional LEADING_ZERO_BLANK_EN
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]                  presc;
  logic                           tick;
  digit_idx_t                     idx;
  digit_idx_t                     idx_next;
  logic [NUM_DIGITS-1:0][3:0]     hold;
  logic [NUM_DIGITS-1:0][3:0]     hold_next;
  logic [3:0]                     sel_code;
  logic [6:0]                     dec_seg;
  logic                           blank;
  logic [6:0]                     seg_next;
  logic [3:0]                     an_next;

  assign tick = (presc == PRESC_LAST);

  // Prescaler free-runs 0..REFRESH_DIV-1 and sets how long each digit stays lit
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Post-edge index and hold values, so outputs track the state they will show
  always_comb begin
    idx_next  = tick ? digit_idx_t'(idx + 2'd1) : idx;
    hold_next = load ? {d3, d2, d1, d0} : hold;
  end

  // Digit index advances on each tick; frame_tick marks the 3 -> 0 wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      idx        <= idx_next;
      frame_tick <= tick && (idx == 2'd3);
    end
  end

  // Hold registers capture a new 4-digit value whenever load is high
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else begin
      hold <= hold_next;
    end
  end

  assign sel_code = hold_next[idx_next];

  bcd_to_7seg u_dec (
    .code (sel_code),
    .seg  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit goes dark when it and every more significant digit are zero; units never blank
  always_comb begin
    blank = 1'b0;
    case (idx_next)
      2'd3:    blank = (hold_next[3] == 4'd0);
      2'd2:    blank = (hold_next[3] == 4'd0) && (hold_next[2] == 4'd0);
      2'd1:    blank = (hold_next[3] == 4'd0) && (hold_next[2] == 4'd0) &&
                       (hold_next[1] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  // Next output drive: one anode low for the selected digit, pattern for its value
  always_comb begin
    an_next  = ~(4'b0001 << idx_next);
    seg_next = blank ? SEG_BLANK : dec_seg;
  end

  // Registered pin drive; everything dark while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule
